// File: rtl/tile_seq_pkg.sv
// tile_seq_pkg: tile geometry, FSM states, inst bit map and ACC address helper for tile_sequencer
package tile_seq_pkg;
  localparam int COL = 8;
  localparam int K_W = 3;
  localparam int IN_W = 6;
  localparam int OUT_W = 4;
  localparam int LEN_KIJ = K_W * K_W;
  localparam int LEN_NIJ = IN_W * IN_W;
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int ADDR_W = 11;
  localparam logic [ADDR_W-1:0] W_BASE = 11'h400;
  localparam int GAP_CYCLES = 10;
  localparam int DRAIN_CYCLES = 30;
  localparam int T_W = 6;
  localparam int INST_W = 34;
  localparam int ACC_B = 33;
  localparam int CEN_P_B = 32;
  localparam int WEN_P_B = 31;
  localparam int A_P_B = 20;
  localparam int CEN_X_B = 19;
  localparam int WEN_X_B = 18;
  localparam int A_X_B = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B = 3;
  localparam int L0_WR_B = 2;
  localparam int EXEC_B = 1;
  localparam int LOAD_B = 0;
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1800C0000;
  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_X_L0, S_X_EXEC, S_DRAIN,
    S_OFIFO_RD, S_CLR, S_READ, S_TAIL, S_DONE
  } state_t;
  function automatic logic [ADDR_W-1:0] acc_addr(input logic [3:0] k, input logic [3:0] onij);
    return ADDR_W'(int'(k) * LEN_NIJ + (int'(onij) / OUT_W + int'(k) / K_W) * IN_W
                   + int'(onij) % OUT_W + int'(k) % K_W);
  endfunction
endpackage

// File: rtl/tile_seq_addr_gen.sv
// tile_seq_addr_gen: pmem address of psum k for output pixel onij during accumulation
module tile_seq_addr_gen
  import tile_seq_pkg::*;
(
  input  logic [3:0]        k,
  input  logic [3:0]        onij,
  output logic [ADDR_W-1:0] addr
);
  logic [3:0] ki, kj, orow, ocol;
  // split kernel/output indices into row and column, then form the psum location
  always_comb begin
    ki = k / 4'(K_W);
    kj = k % 4'(K_W);
    orow = onij / 4'(OUT_W);
    ocol = onij % 4'(OUT_W);
    addr = ADDR_W'(k) * ADDR_W'(LEN_NIJ) + (ADDR_W'(orow) + ADDR_W'(ki)) * ADDR_W'(IN_W)
           + ADDR_W'(ocol) + ADDR_W'(kj);
  end
endmodule

// File: rtl/tile_sequencer.sv
// tile_sequencer: on-chip instruction generator for one output tile of the systolic core (TILE_SEQ_PERF_EN adds cycle/stall counters)
module tile_sequencer
  import tile_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic [3:0]        kij,
  output logic              sfp_clr,
  output logic              busy,
`ifdef TILE_SEQ_PERF_EN
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic              done
);
  if (LEN_KIJ * LEN_NIJ > 2 ** ADDR_W || LEN_KIJ * LEN_NIJ > int'(W_BASE) || OUT_W != IN_W - K_W + 1) begin : g_bad_cfg
    $error("tile_sequencer: psum region does not fit below w_base or geometry inconsistent");
  end
  state_t state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic [3:0] kij_q, kij_d, onij_q, onij_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic sfp_clr_q, sfp_clr_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] acc_a;
  tile_seq_addr_gen u_addr (
    .k    (t_q[3:0]),
    .onij (onij_q),
    .addr (acc_a)
  );
  // next state and the instruction for the current phase cycle (registered, so inst trails state by one cycle)
  always_comb begin
    state_d = state_q;
    t_d = t_q + 6'd1;
    kij_d = kij_q;
    onij_d = onij_q;
    inst_d = IDLE_INST;
    sfp_clr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        t_d = '0;
        if (start) begin
          state_d = S_W_L0;
          kij_d = '0;
          onij_d = '0;
        end
      end
      S_W_L0: begin
        inst_d[CEN_X_B] = 1'b0;
        inst_d[A_X_B +: ADDR_W] = W_BASE + ADDR_W'(t_q);
        inst_d[L0_WR_B] = 1'b1;
        if (t_q == T_W'(COL - 1)) begin
          state_d = S_W_LOAD;
          t_d = '0;
        end
      end
      S_W_LOAD: begin
        inst_d[L0_RD_B] = 1'b1;
        inst_d[LOAD_B] = 1'b1;
        if (t_q == T_W'(COL - 1)) begin
          state_d = S_GAP;
          t_d = '0;
        end
      end
      S_GAP: begin
        if (t_q == T_W'(GAP_CYCLES - 1)) begin
          state_d = S_X_L0;
          t_d = '0;
        end
      end
      S_X_L0: begin
        inst_d[CEN_X_B] = 1'b0;
        inst_d[A_X_B +: ADDR_W] = ADDR_W'(t_q);
        inst_d[L0_WR_B] = 1'b1;
        if (t_q == T_W'(LEN_NIJ - 1)) begin
          state_d = S_X_EXEC;
          t_d = '0;
        end
      end
      S_X_EXEC: begin
        inst_d[L0_RD_B] = 1'b1;
        inst_d[EXEC_B] = 1'b1;
        if (t_q == T_W'(LEN_NIJ - 1)) begin
          state_d = S_DRAIN;
          t_d = '0;
        end
      end
      S_DRAIN: begin
        if (t_q == T_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_OFIFO_RD;
          t_d = '0;
        end
      end
      S_OFIFO_RD: begin
        t_d = t_q;
        if (ofifo_valid) begin
          inst_d[OFIFO_RD_B] = 1'b1;
          inst_d[CEN_P_B] = 1'b0;
          inst_d[WEN_P_B] = 1'b0;
          inst_d[A_P_B +: ADDR_W] = ADDR_W'(kij_q) * ADDR_W'(LEN_NIJ) + ADDR_W'(t_q);
          t_d = t_q + 6'd1;
          if (t_q == T_W'(LEN_NIJ - 1)) begin
            t_d = '0;
            state_d = kij_q == 4'(LEN_KIJ - 1) ? S_CLR : S_W_L0;
            kij_d = kij_q == 4'(LEN_KIJ - 1) ? 4'd0 : kij_q + 4'd1;
            onij_d = '0;
          end
        end
      end
      S_CLR: begin
        sfp_clr_d = 1'b1;
        t_d = '0;
        state_d = S_READ;
      end
      S_READ: begin
        inst_d[CEN_P_B] = 1'b0;
        inst_d[A_P_B +: ADDR_W] = acc_a;
        inst_d[ACC_B] = t_q != '0;
        if (t_q == T_W'(LEN_KIJ - 1)) begin
          state_d = S_TAIL;
          t_d = '0;
        end
      end
      S_TAIL: begin
        inst_d[ACC_B] = 1'b1;
        t_d = '0;
        state_d = onij_q == 4'(LEN_ONIJ - 1) ? S_DONE : S_CLR;
        onij_d = onij_q == 4'(LEN_ONIJ - 1) ? onij_q : onij_q + 4'd1;
      end
      S_DONE: begin
        t_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        t_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = state_d != S_IDLE && state_d != S_DONE;
    done_d = state_d == S_DONE;
  end
  // state, phase counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      t_q <= '0;
      kij_q <= '0;
      onij_q <= '0;
      inst_q <= IDLE_INST;
      sfp_clr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      kij_q <= kij_d;
      onij_q <= onij_d;
      inst_q <= inst_d;
      sfp_clr_q <= sfp_clr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign inst = inst_q;
  assign kij = kij_q;
  assign sfp_clr = sfp_clr_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef TILE_SEQ_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, stall_cnt_q, stall_cnt_d;
  logic start_acc;
  // saturating busy/stall counters, restarted by each accepted start and held after done
  always_comb begin
    start_acc = state_q == S_IDLE && start;
    cyc_cnt_d = start_acc ? '0 : cyc_cnt_q + 32'(busy_q && cyc_cnt_q != '1);
    stall_cnt_d = start_acc ? '0
                : stall_cnt_q + 32'(state_q == S_OFIFO_RD && !ofifo_valid && stall_cnt_q != '1);
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign cyc_cnt = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule
